// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS generator:
// wave-mode encoding, step counts and offset-binary scale helpers.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_mode_e;

  localparam int AMP_STEPS   = 4;
  localparam int PHASE_STEPS = 4;

  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned fullscale(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic wave_mode_e next_mode(input wave_mode_e m);
    case (m)
      WAVE_SINE:     return WAVE_SQUARE;
      WAVE_SQUARE:   return WAVE_TRIANGLE;
      WAVE_TRIANGLE: return WAVE_SAW;
      default:       return WAVE_SINE;
    endcase
  endfunction

endpackage

// File: rtl/dds_multi_wave_gen_sine_lut.sv
// Quarter-wave sine magnitude ROM (combinational). Entries are built at
// elaboration from an integer rational sine approximation, exact at 0 and 90 deg.
module dds_sine_lut #(
  parameter int LUT_AW = 8,
  parameter int MAG_W  = 11
) (
  input  logic [LUT_AW-1:0] addr_i,
  output logic [MAG_W-1:0]  mag_o
);

  function automatic logic [MAG_W-1:0] sine_entry(input int idx);
    longint h, x, num, den, full;
    h    = longint'(1) <<< (LUT_AW + 1);
    x    = longint'(idx) * (h - longint'(idx));
    full = (longint'(1) <<< MAG_W) - 1;
    num  = 4 * x * full;
    den  = (5 * h * h) / 4 - x;
    return MAG_W'((num + den / 2) / den);
  endfunction

  logic [MAG_W-1:0] rom [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    assign rom[i] = sine_entry(i);
  end

  assign mag_o = rom[addr_i];

endmodule

// File: rtl/dds_multi_wave_gen.sv
// Multi-channel DDS generator: per-channel accumulator, shaping and attenuation.
// Optional WAVE_SYNC_EN adds sync_in, whose rising edge zeroes all accumulators.
module dds_multi_wave_gen
  import dds_pkg::*;
#(
  parameter int              N_CH       = 2,
  parameter int              ACC_W      = 32,
  parameter int              LUT_AW     = 8,
  parameter int              OUT_W      = 12,
  parameter int              F_LEVELS   = 4,
  parameter logic [ACC_W-1:0] FSTEP_BASE = 32'h0040_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             ch_sel,
  input  logic                   W_ctrl,
  input  logic                   A_ctrl,
  input  logic                   P_ctrl,
  input  logic                   F_ctrl,
`ifdef WAVE_SYNC_EN
  input  logic                   sync_in,
`endif
  output logic [N_CH*OUT_W-1:0]  wave_out,
  output logic                   cfg_busy
);

  localparam int PW   = LUT_AW + 2;
  localparam int FI_W = (F_LEVELS > 1) ? $clog2(F_LEVELS) : 1;
  localparam logic [FI_W-1:0]      FI_MAX = FI_W'(F_LEVELS - 1);
  localparam logic [OUT_W-1:0]     MID    = OUT_W'(midscale(OUT_W));
  localparam logic [OUT_W-1:0]     FULL   = OUT_W'(fullscale(OUT_W));
  localparam logic signed [OUT_W:0] MID_S = $signed({1'b0, MID});

  // bit order: {F, P, A, W}
  logic [3:0] ctrl, ctrl_q, stp;
  logic       cfg_busy_d, cfg_busy_q;
  logic       sync_edge;

  assign ctrl       = {F_ctrl, P_ctrl, A_ctrl, W_ctrl};
  assign stp        = ctrl & ~ctrl_q;
  assign cfg_busy_d = |stp;
  assign cfg_busy   = cfg_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      cfg_busy_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl;
      cfg_busy_q <= cfg_busy_d;
    end
  end

`ifdef WAVE_SYNC_EN
  logic sync_q;
  assign sync_edge = sync_in & ~sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 1'b0;
    else        sync_q <= sync_in;
  end
`else
  assign sync_edge = 1'b0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    wave_mode_e              mode_q, mode_d;
    logic [1:0]              amp_q, amp_d, ph_q, ph_d, amp_s2_q;
    logic [FI_W-1:0]         fidx_q, fidx_d;
    logic [ACC_W-1:0]        acc_q, acc_d, fw;
    logic [PW-1:0]           p;
    logic [PW-2:0]           tri_fold;
    logic [LUT_AW-1:0]       lut_addr;
    logic [OUT_W-2:0]        lut_mag;
    logic [OUT_W-1:0]        sine_v, saw_v, tri_v, shape_d, shape_q, out_d, out_q;
    logic signed [OUT_W:0]   dev, dev_sh;
    logic                    hit;

    // Out-of-range ch_sel matches no channel, so the step is dropped.
    assign hit = (ch_sel == 3'(c));

    always_comb begin
      mode_d = mode_q;
      amp_d  = amp_q;
      ph_d   = ph_q;
      fidx_d = fidx_q;
      if (hit && stp[0]) mode_d = next_mode(mode_q);
      if (hit && stp[1]) amp_d  = (amp_q == 2'(AMP_STEPS - 1)) ? 2'd0 : amp_q + 2'd1;
      if (hit && stp[2]) ph_d   = (ph_q == 2'(PHASE_STEPS - 1)) ? 2'd0 : ph_q + 2'd1;
      if (hit && stp[3]) fidx_d = (fidx_q == FI_MAX) ? '0 : fidx_q + FI_W'(1);
    end

    assign fw    = FSTEP_BASE << fidx_q;
    assign acc_d = sync_edge ? '0 : acc_q + fw;

    // Phase offset rotates by quarter turns without touching the accumulator.
    assign p        = acc_q[ACC_W-1 -: PW] + {ph_q, {LUT_AW{1'b0}}};
    assign lut_addr = p[PW-2] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
    assign tri_fold = p[PW-1] ? ~p[PW-2:0] : p[PW-2:0];

    if (OUT_W >= PW) begin : g_scale_up
      assign saw_v = OUT_W'(p) << (OUT_W - PW);
      assign tri_v = OUT_W'(tri_fold) << (OUT_W - PW + 1);
    end else begin : g_scale_dn
      assign saw_v = p[PW-1 -: OUT_W];
      assign tri_v = tri_fold[PW-2 -: OUT_W];
    end

    dds_sine_lut #(
      .LUT_AW (LUT_AW),
      .MAG_W  (OUT_W - 1)
    ) u_lut (
      .addr_i (lut_addr),
      .mag_o  (lut_mag)
    );

    always_comb begin
      sine_v  = p[PW-1] ? (MID - OUT_W'(lut_mag)) : (MID + OUT_W'(lut_mag));
      shape_d = sine_v;
      case (mode_q)
        WAVE_SQUARE:   shape_d = p[PW-1] ? '0 : FULL;
        WAVE_TRIANGLE: shape_d = tri_v;
        WAVE_SAW:      shape_d = saw_v;
        default:       shape_d = sine_v;
      endcase
    end

    always_comb begin
      dev    = $signed({1'b0, shape_q}) - MID_S;
      dev_sh = dev >>> amp_s2_q;
      out_d  = OUT_W'(dev_sh + MID_S);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q   <= WAVE_SINE;
        amp_q    <= '0;
        ph_q     <= '0;
        fidx_q   <= '0;
        acc_q    <= '0;
        shape_q  <= MID;
        amp_s2_q <= '0;
        out_q    <= MID;
      end else begin
        mode_q   <= mode_d;
        amp_q    <= amp_d;
        ph_q     <= ph_d;
        fidx_q   <= fidx_d;
        acc_q    <= acc_d;
        shape_q  <= shape_d;
        amp_s2_q <= amp_q;
        out_q    <= out_d;
      end
    end

    assign wave_out[c*OUT_W +: OUT_W] = out_q;
  end

endmodule

// File: tb/tb_dds_multi_wave_gen.sv
// Directed self-checking bench for dds_multi_wave_gen (default 2 channels, 12-bit).
module tb_dds_multi_wave_gen;

  localparam int N_CH  = 2;
  localparam int OUT_W = 12;
  localparam int MID   = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] ch_sel = 3'd0;
  logic W_ctrl = 1'b0, A_ctrl = 1'b0, P_ctrl = 1'b0, F_ctrl = 1'b0;
`ifdef WAVE_SYNC_EN
  logic sync_in = 1'b0;
`endif
  logic [N_CH*OUT_W-1:0] wave_out;
  logic cfg_busy;

  int checks = 0, failures = 0;
  int cyc = 0, busy_cnt = 0;
  int cur0 = MID, prev0 = MID, cur1 = MID;
  int maxdiff = 0;
  bit track = 1'b0;
  int w_max, w_min, n_hi1, n_lo1;
  int per;

  always #5 clk = ~clk;

  dds_multi_wave_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_sel   (ch_sel),
    .W_ctrl   (W_ctrl),
    .A_ctrl   (A_ctrl),
    .P_ctrl   (P_ctrl),
    .F_ctrl   (F_ctrl),
`ifdef WAVE_SYNC_EN
    .sync_in  (sync_in),
`endif
    .wave_out (wave_out),
    .cfg_busy (cfg_busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      prev0 = cur0;
      cur0  = int'(wave_out[0 +: OUT_W]);
      cur1  = int'(wave_out[OUT_W +: OUT_W]);
      if (cfg_busy) busy_cnt++;
      d = (cur0 > prev0) ? cur0 - prev0 : prev0 - cur0;
      if (track && d > maxdiff) maxdiff = d;
    end
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic pulse(input logic [3:0] fpaw);
    {F_ctrl, P_ctrl, A_ctrl, W_ctrl} = fpaw;
    tick(1);
    {F_ctrl, P_ctrl, A_ctrl, W_ctrl} = 4'b0000;
    tick(3);
  endtask

  task automatic window(input int n);
    w_max = -1; w_min = 1 << 30; n_hi1 = 0; n_lo1 = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (cur0 > w_max) w_max = cur0;
      if (cur0 < w_min) w_min = cur0;
      if (cur1 == 4095) n_hi1++;
      if (cur1 == 0)    n_lo1++;
    end
  endtask

  // Cycles between two successive upward midscale crossings of channel 0.
  task automatic measure_period(output int p_out);
    int n, t0;
    p_out = -1;
    n = 0;
    tick(1);
    while (!(prev0 < MID && cur0 >= MID) && n < 4000) begin tick(1); n++; end
    if (n >= 4000) return;
    t0 = cyc;
    n = 0;
    tick(1);
    while (!(prev0 < MID && cur0 >= MID) && n < 4000) begin tick(1); n++; end
    if (n >= 4000) return;
    p_out = cyc - t0;
  endtask

  initial begin
    // reset state and free-running sine on both channels
    tick(3);
    check("rst_ch0", int'(wave_out[0 +: OUT_W]), MID);
    check("rst_ch1", int'(wave_out[OUT_W +: OUT_W]), MID);
    check("rst_busy", int'(cfg_busy), 0);
    rst_n = 1'b1;
    cyc = 0;
    tick_to(2);   check("sine_p0", cur0, 2048);
    tick_to(258); check("sine_p256_ch0", cur0, 4095);
                  check("sine_p256_ch1", cur1, 4095);
    tick_to(514); check("sine_p512", cur0, 2048);
    tick_to(770); check("sine_p768", cur0, 1);

    // held W level on ch1 gives a single step to SQUARE
    ch_sel = 3'd1;
    busy_cnt = 0;
    W_ctrl = 1'b1;
    tick(50);
    W_ctrl = 1'b0;
    tick(10);
    check("w_hold_busy", busy_cnt, 1);
    window(1024);
    check("sq_ch1_hi", n_hi1, 512);
    check("sq_ch1_lo", n_lo1, 512);
    check("ch0_keep_max", w_max, 4095);
    check("ch0_keep_min", w_min, 1);

    // amplitude steps on ch0
    ch_sel = 3'd0;
    pulse(4'b0010);
    pulse(4'b0010);
    window(1024);
    check("amp2_max", w_max, 2559);
    check("amp2_min", w_min, 1536);
    pulse(4'b0010);
    pulse(4'b0010);
    window(1024);
    check("amp0_max", w_max, 4095);
    check("amp0_min", w_min, 1);

    // frequency levels on ch0, phase-continuous switching
    maxdiff = 0;
    track = 1'b1;
    pulse(4'b1000); measure_period(per); check("period_f1", per, 512);
    pulse(4'b1000); measure_period(per); check("period_f2", per, 256);
    pulse(4'b1000); measure_period(per); check("period_f3", per, 128);
    pulse(4'b1000); measure_period(per); check("period_wrap", per, 1024);
    track = 1'b0;
    check("f_continuity", int'(maxdiff <= 110), 1);

    // asynchronous reset mid-waveform
    rst_n = 1'b0;
    #1;
    check("arst_ch0", int'(wave_out[0 +: OUT_W]), MID);
    check("arst_ch1", int'(wave_out[OUT_W +: OUT_W]), MID);
    check("arst_busy", int'(cfg_busy), 0);
    tick(2);
    rst_n = 1'b1;
    cyc = 0;
    tick_to(2);
    check("post_rst_ch0", cur0, MID);
    check("post_rst_ch1", cur1, MID);

    // out-of-range channel: busy pulses, nothing changes
    tick_to(10);
    ch_sel = 3'd5;
    busy_cnt = 0;
    pulse(4'b1111);
    check("oor_busy", busy_cnt, 1);
    tick_to(258);
    check("oor_ch0_p256", cur0, 4095);
    check("oor_ch1_p256", cur1, 4095);
    tick_to(770);
    check("oor_ch0_p768", cur0, 1);
    check("oor_ch1_p768", cur1, 1);

    // W+P together on ch0 at edge cycle 1536 (phase 512)
    ch_sel = 3'd0;
    tick_to(1536);
    W_ctrl = 1'b1;
    P_ctrl = 1'b1;
    tick(1);
    check("wp_busy", int'(cfg_busy), 1);
    W_ctrl = 1'b0;
    P_ctrl = 1'b0;
    tick(1);      check("wp_edge_plus2", cur0, 2048);
    tick(1);      check("wp_edge_plus3", cur0, 0);
    tick_to(1793); check("wp_sq_lo", cur0, 0);
    tick(1);       check("wp_sq_hi", cur0, 4095);
                   check("wp_ch1_sine", cur1, 1);

`ifdef WAVE_SYNC_EN
    // bring ch1 to ch0's config but a different phase, then sync
    ch_sel = 3'd1;
    pulse(4'b1000);
    tick(100);
    pulse(4'b1000);
    pulse(4'b1000);
    pulse(4'b1000);
    pulse(4'b0101);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    tick(4);
    for (int i = 0; i < 6; i++) begin
      tick(37);
      check("sync_equal", cur1, cur0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
